// File: rtl/pixel_histogram.sv
// ---------------------------------------------------------------------------
// pixel_histogram
//
// Builds a per-frame intensity histogram of a parallel pixel stream
// (pd/fv/lv) in on-chip block RAM. When the frame ends, all bins are streamed
// out over a valid/ready port in bin order 0..N-1. The RAM is then cleared for
// the next frame.
//
// Build option:
//   HIST_SUM_EN  - when defined, the block also keeps a saturating count of
//                  all valid pixels. It sends that count as one extra beat
//                  after bin N-1 (bin=0, data=sum, last=1). When undefined,
//                  last is asserted on bin N-1 and the dump is N beats.
//
// Ports:
//   clk_pixel     pixel clock, sole clock
//   reset         synchronous, active-high
//   pd_i          pixel data; bin = pd_i[PIX_W-1 -: BIN_BITS]
//   fv_i, lv_i    frame / line valid; a pixel counts when both are high
//                 while accumulating
//   hist_ready_i  sink ready
//   hist_valid_o  beat valid
//   hist_data_o   bin count (or pixel sum on the extra beat)
//   hist_bin_o    bin index of the current beat
//   hist_last_o   final beat of the dump
//   busy_o        high while clearing, draining or dumping
//   frame_drop_o  frames skipped while busy (wraps)
// ---------------------------------------------------------------------------
module pixel_histogram #(
  parameter int PIX_W    = 10,
  parameter int BIN_BITS = 10,
  parameter int CNT_W    = 24
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [PIX_W-1:0]    pd_i,
  input  logic                fv_i,
  input  logic                lv_i,
  input  logic                hist_ready_i,
  output logic                hist_valid_o,
  output logic [CNT_W-1:0]    hist_data_o,
  output logic [BIN_BITS-1:0] hist_bin_o,
  output logic                hist_last_o,
  output logic                busy_o,
  output logic [7:0]          frame_drop_o
);

  localparam int N = 2 ** BIN_BITS;
`ifdef HIST_SUM_EN
  localparam int NBEATS = N + 1;
`else
  localparam int NBEATS = N;
`endif
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [BIN_BITS:0] BEATS_END  = (BIN_BITS + 1)'(NBEATS);
  localparam logic [BIN_BITS:0] BEATS_LAST = (BIN_BITS + 1)'(NBEATS - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DUMP
  } state_t;

  state_t state_q, state_d;

  // Frame-edge detection
  logic fv_q;
  logic fv_rise, fv_fall;
  assign fv_rise = fv_i & ~fv_q;
  assign fv_fall = ~fv_i & fv_q;

  // Sequencing state
  logic [BIN_BITS-1:0] clr_addr_q;
  logic                drain_q;
  logic [7:0]          drop_q;

  // Decoded controls from the output process
  logic clr_we, accum_en, dump_en;

  // Accumulate pipeline
  logic                pix_valid;
  logic [BIN_BITS-1:0] pix_bin;
  logic                s2_valid_q;
  logic [BIN_BITS-1:0] s2_bin_q;
  logic                wb_valid_q;
  logic [BIN_BITS-1:0] wb_bin_q;
  logic [CNT_W-1:0]    wb_data_q;
  logic [CNT_W-1:0]    s2_base, s2_inc;

  // Block RAM ports
  logic [CNT_W-1:0]    mem_q [N];
  logic [CNT_W-1:0]    ram_rdata_q;
  logic                ram_we, ram_re;
  logic [BIN_BITS-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0]    ram_wdata;

  // Dump engine
  logic [BIN_BITS:0]   issue_cnt_q;
  logic                pend_q;
  logic [BIN_BITS-1:0] pend_bin_q;
  logic                pend_last_q;
  logic                hist_valid_q;
  logic [CNT_W-1:0]    hist_data_q;
  logic [BIN_BITS-1:0] hist_bin_q;
  logic                hist_last_q;
  logic                dump_accept, dump_load, dump_issue;
  logic [CNT_W-1:0]    load_data;

`ifdef HIST_SUM_EN
  logic [CNT_W-1:0]    sum_q;
  logic                pend_sum_q;
`endif

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (&clr_addr_q)                state_d = S_IDLE;
      S_IDLE:  if (fv_rise)                    state_d = S_ACCUM;
      S_ACCUM: if (fv_fall)                    state_d = S_DRAIN;
      S_DRAIN: if (drain_q)                    state_d = S_DUMP;
      S_DUMP:  if (dump_accept && hist_last_q) state_d = S_CLEAR;
      default:                                 state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    busy_o   = 1'b0;
    clr_we   = 1'b0;
    accum_en = 1'b0;
    dump_en  = 1'b0;
    case (state_q)
      S_CLEAR: begin busy_o = 1'b1; clr_we = 1'b1; end
      S_ACCUM: accum_en = 1'b1;
      S_DRAIN: busy_o = 1'b1;
      S_DUMP:  begin busy_o = 1'b1; dump_en = 1'b1; end
      default: ;
    endcase
  end

  // ---------------------------------------------------------- sequencing ---
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      fv_q       <= 1'b0;
      clr_addr_q <= '0;
      drain_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      fv_q       <= fv_i;
      clr_addr_q <= clr_we ? clr_addr_q + BIN_BITS'(1) : '0;
      drain_q    <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
      // A frame that starts while busy is never accumulated.
      if (fv_rise && busy_o) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------- accumulate (RMW) ---
  assign pix_bin   = pd_i[PIX_W-1 -: BIN_BITS];
  assign pix_valid = accum_en & fv_i & lv_i;

  // The read for a pixel is issued on the same edge as the previous pixel's
  // write. So its RAM data may be stale if the two pixels share a bin. The
  // write just committed (wb_*) is kept one extra cycle and substituted when
  // the bins match. This way the count never depends on the RAM's
  // read-during-write behaviour, and runs of one bin count exactly.
  always_comb begin
    s2_base = (wb_valid_q && (wb_bin_q == s2_bin_q)) ? wb_data_q : ram_rdata_q;
    s2_inc  = (s2_base == CNT_MAX) ? s2_base : s2_base + CNT_W'(1);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_bin_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      s2_valid_q <= pix_valid;
      s2_bin_q   <= pix_bin;
      wb_valid_q <= s2_valid_q;
      wb_bin_q   <= s2_bin_q;
      wb_data_q  <= s2_inc;
    end
  end

`ifdef HIST_SUM_EN
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sum_q <= '0;
    end else if ((state_q == S_IDLE) && fv_rise) begin
      sum_q <= '0;
    end else if (pix_valid && (sum_q != CNT_MAX)) begin
      sum_q <= sum_q + CNT_W'(1);
    end
  end
`endif

  // ----------------------------------------------------------- block RAM ---
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s2_bin_q;
    ram_wdata = s2_inc;
    if (clr_we) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end else if (s2_valid_q) begin
      ram_we = 1'b1;
    end
    ram_re    = pix_valid | dump_issue;
    ram_raddr = dump_en ? issue_cnt_q[BIN_BITS-1:0] : pix_bin;
  end

  always_ff @(posedge clk_pixel) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
    if (ram_re) begin
      ram_rdata_q <= mem_q[ram_raddr];
    end
  end

  // --------------------------------------------------------- dump engine ---
  // One read may be in flight (pend_q). Its data sits in ram_rdata_q until
  // the output register can take it. The next read is issued only when that
  // slot frees up, so ram_rdata_q is never overwritten before it is used.
  assign dump_accept = hist_valid_q & hist_ready_i;
  assign dump_load   = pend_q & (~hist_valid_q | hist_ready_i);
  assign dump_issue  = dump_en & (issue_cnt_q != BEATS_END) & (~pend_q | dump_load);

`ifdef HIST_SUM_EN
  assign load_data = pend_sum_q ? sum_q : ram_rdata_q;
`else
  assign load_data = ram_rdata_q;
`endif

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      issue_cnt_q  <= '0;
      pend_q       <= 1'b0;
      pend_bin_q   <= '0;
      pend_last_q  <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_data_q  <= '0;
      hist_bin_q   <= '0;
      hist_last_q  <= 1'b0;
`ifdef HIST_SUM_EN
      pend_sum_q   <= 1'b0;
`endif
    end else begin
      if (!dump_en) begin
        issue_cnt_q <= '0;
        pend_q      <= 1'b0;
      end else if (dump_issue) begin
        issue_cnt_q <= issue_cnt_q + (BIN_BITS + 1)'(1);
        pend_q      <= 1'b1;
        // The sum beat (index N) wraps to bin 0.
        pend_bin_q  <= issue_cnt_q[BIN_BITS-1:0];
        pend_last_q <= (issue_cnt_q == BEATS_LAST);
`ifdef HIST_SUM_EN
        pend_sum_q  <= issue_cnt_q[BIN_BITS];
`endif
      end else if (dump_load) begin
        pend_q <= 1'b0;
      end

      if (dump_load) begin
        hist_valid_q <= 1'b1;
        hist_data_q  <= load_data;
        hist_bin_q   <= pend_bin_q;
        hist_last_q  <= pend_last_q;
      end else if (dump_accept) begin
        hist_valid_q <= 1'b0;
      end
    end
  end

  assign hist_valid_o = hist_valid_q;
  assign hist_data_o  = hist_data_q;
  assign hist_bin_o   = hist_bin_q;
  assign hist_last_o  = hist_last_q;
  assign frame_drop_o = drop_q;

endmodule

// File: tb/tb_pixel_histogram.sv
// ---------------------------------------------------------------------------
// tb_pixel_histogram
//
// Drives frames into two lockstep instances of pixel_histogram: the default
// build (24-bit counters) and a 4-bit-counter build that exercises
// saturation. Every dumped beat is checked against a per-bin count model
// that the bench builds from the pixels it sends.
// ---------------------------------------------------------------------------
module tb_pixel_histogram;

  localparam int N = 1024;
`ifdef HIST_SUM_EN
  localparam int NBEATS = N + 1;
`else
  localparam int NBEATS = N;
`endif
  localparam longint BIG_MAX   = (64'd1 << 24) - 1;
  localparam longint SMALL_MAX = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic fv    = 1'b0;
  logic lv    = 1'b0;
  logic ready = 1'b0;
  logic [9:0] pd = '0;

  logic        valid_b, last_b, busy_b;
  logic [23:0] data_b;
  logic [9:0]  bin_b;
  logic [7:0]  drop_b;
  logic        valid_s, last_s, busy_s;
  logic [3:0]  data_s;
  logic [9:0]  bin_s;
  logic [7:0]  drop_s;

  int     tests_run    = 0;
  int     tests_failed = 0;
  int     exp_cnt [N];
  longint exp_total;
  int     exp_drops;
  int     pix_q [$];

  always #5 clk = ~clk;

  pixel_histogram dut (
    .clk_pixel    (clk),
    .reset        (reset),
    .pd_i         (pd),
    .fv_i         (fv),
    .lv_i         (lv),
    .hist_ready_i (ready),
    .hist_valid_o (valid_b),
    .hist_data_o  (data_b),
    .hist_bin_o   (bin_b),
    .hist_last_o  (last_b),
    .busy_o       (busy_b),
    .frame_drop_o (drop_b)
  );

  pixel_histogram #(.CNT_W(4)) dut_s (
    .clk_pixel    (clk),
    .reset        (reset),
    .pd_i         (pd),
    .fv_i         (fv),
    .lv_i         (lv),
    .hist_ready_i (ready),
    .hist_valid_o (valid_s),
    .hist_data_o  (data_s),
    .hist_bin_o   (bin_s),
    .hist_last_o  (last_s),
    .busy_o       (busy_s),
    .frame_drop_o (drop_s)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    exp_total = 0;
  endtask

  // Hold reset for one edge, check the reset state, then time the clear.
  task automatic reset_and_clear(input string tag);
    int n;
    bit saw_valid;
    reset = 1'b1; fv = 1'b0; lv = 1'b0; ready = 1'b0;
    cyc();
    chk({tag, "_rst_valid"}, valid_b, 0);
    chk({tag, "_rst_valid_s"}, valid_s, 0);
    chk({tag, "_rst_data"}, data_b, 0);
    chk({tag, "_rst_bin"}, bin_b, 0);
    chk({tag, "_rst_last"}, last_b, 0);
    chk({tag, "_rst_busy"}, busy_b, 1);
    chk({tag, "_rst_drop"}, drop_b, 0);
    reset = 1'b0;
    model_clear();
    exp_drops = 0;
    n = 0;
    saw_valid = 1'b0;
    while (busy_b === 1'b1 && n < 3000) begin
      if (valid_b !== 1'b0) saw_valid = 1'b1;
      n++;
      cyc();
    end
    chk({tag, "_busy_cycles"}, n, N);
    chk({tag, "_valid_in_clear"}, saw_valid, 0);
    chk({tag, "_drop_after_clear"}, drop_b, 0);
    $display("[TB] %s: reset done, busy for %0d cycles", tag, n);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_b !== 1'b0 && n < 3000) begin
      n++;
      cyc();
    end
    chk("idle_wait", busy_b, 0);
  endtask

  // Sends pix_q as one frame and adds it to the model. Ends with fv
  // driven low, so the next edge is the frame-valid fall.
  task automatic send_frame(input int line_len);
    wait_idle();
    fv = 1'b1; lv = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < pix_q.size(); i++) begin
      lv = 1'b1;
      pd = 10'(pix_q[i]);
      exp_cnt[pix_q[i]]++;
      exp_total++;
      cyc();
      if ((i + 1) % line_len == 0) begin
        lv = 1'b0;
        cyc();
        cyc();
      end
    end
    lv = 1'b0;
    cyc();
    fv = 1'b0;
  endtask

  task automatic fill_random(input int n);
    int v = 0;
    pix_q.delete();
    for (int i = 0; i < n; i++) begin
      // About a third of the pixels repeat the previous value.
      if (i == 0 || $urandom_range(2) != 0) v = int'($urandom_range(1023));
      pix_q.push_back(v);
    end
  endtask

  // Collects the dump. inject_at >= 0 starts a new frame once that many
  // beats have been accepted. abort_at >= 0 asserts reset once that many
  // beats have been accepted.
  task automatic run_dump(input string tag, input int ready_pct, input int inject_at,
                          input int abort_at, output bit aborted);
    int idx = 0;
    int k = 0;
    int inj_t = -1;
    bit seen_valid = 1'b0;
    bit stall = 1'b0;
    bit done = 1'b0;
    logic [23:0] h_data = '0;
    logic [9:0]  h_bin = '0;
    logic        h_last = 1'b0;
    longint e;
    aborted = 1'b0;
    while (!done && k < 20000) begin
      if (valid_b === 1'b1 && !seen_valid) begin
        seen_valid = 1'b1;
        chk({tag, "_first_valid_within_5"}, (k <= 5), 1);
      end
      if (stall) begin
        chk({tag, "_hold_valid"}, valid_b, 1);
        chk({tag, "_hold_data"}, data_b, h_data);
        chk({tag, "_hold_bin"}, bin_b, h_bin);
        chk({tag, "_hold_last"}, last_b, h_last);
      end
      ready = ($urandom_range(99) < ready_pct);
      if (valid_b === 1'b1 && ready) begin
        e = (idx < N) ? longint'(exp_cnt[idx]) : exp_total;
        chk({tag, "_bin"}, bin_b, (idx < N) ? idx : 0);
        chk({tag, "_data"}, data_b, (e > BIG_MAX) ? BIG_MAX : e);
        chk({tag, "_data_sat4"}, data_s, (e > SMALL_MAX) ? SMALL_MAX : e);
        chk({tag, "_valid_sat4"}, valid_s, 1);
        chk({tag, "_last"}, last_b, (idx == NBEATS - 1));
        idx++;
        if (last_b === 1'b1) done = 1'b1;
      end
      stall  = (valid_b === 1'b1) && !ready;
      h_data = data_b;
      h_bin  = bin_b;
      h_last = last_b;
      if (inject_at >= 0 && idx >= inject_at && inj_t < 0) inj_t = 0;
      if (inj_t >= 0 && inj_t < 9) begin
        if (inj_t == 0) begin
          fv = 1'b1;
          exp_drops++;
        end else if (inj_t <= 6) begin
          lv = 1'b1;
          pd = 10'($urandom_range(1023));
        end else if (inj_t == 7) begin
          lv = 1'b0;
        end else begin
          fv = 1'b0;
        end
        inj_t++;
      end
      if (abort_at >= 0 && idx >= abort_at) begin
        reset = 1'b1;
        aborted = 1'b1;
        $display("[TB] %s: reset asserted after %0d beats", tag, idx);
        return;
      end
      cyc();
      k++;
    end
    chk({tag, "_beats"}, idx, NBEATS);
    chk({tag, "_frame_drop"}, drop_b, exp_drops);
    $display("[TB] %s: %0d beats accepted in %0d cycles, frame_drop=%0d", tag, idx, k, drop_b);
    model_clear();
  endtask

  initial begin
    bit ab;
    model_clear();
    exp_drops = 0;

    // Reset state and the clear sweep that follows it.
    reset_and_clear("reset");

    // 4 lines x 8 px of value 5 (also saturates the 4-bit instance).
    pix_q.delete();
    repeat (32) pix_q.push_back(5);
    send_frame(8);
    run_dump("flat5", 100, -1, -1, ab);

    // Every bin once, then a run of 7s to stress forwarding.
    pix_q.delete();
    for (int i = 0; i < N; i++) pix_q.push_back(i);
    repeat (3) pix_q.push_back(7);
    send_frame(N + 3);
    run_dump("ramp_run7", 100, -1, -1, ab);

    // Random frame, 50% ready; a new frame starts mid-dump and is dropped.
    fill_random(120);
    send_frame(40);
    run_dump("rand_drop", 50, 300, -1, ab);

    // The frame after the drop is counted normally.
    fill_random(128);
    send_frame(64);
    run_dump("rand_after_drop", 50, -1, -1, ab);

    // 20 px of value 3: the 4-bit instance holds at 15.
    pix_q.delete();
    repeat (20) pix_q.push_back(3);
    send_frame(20);
    run_dump("sat3", 100, -1, -1, ab);

    // Reset in the middle of a dump.
    fill_random(60);
    send_frame(30);
    run_dump("abort", 50, -1, 100, ab);
    chk("abort_reached", ab, 1);
    reset_and_clear("abort_reset");

    // The next frame holds only its own pixels; includes both extreme bins.
    fill_random(50);
    pix_q.push_back(1023);
    pix_q.push_back(1023);
    pix_q.push_back(0);
    send_frame(53);
    run_dump("post_abort", 70, -1, -1, ab);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
